// File: rtl/enigma_ctrl.sv
// enigma_ctrl: steps three external rotors, then pushes one character through them in order.
// Optional ALPHA_CHECK_EN: characters outside 'A'..'Z' bypass the rotors unchanged.
module enigma_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  input  logic        dec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_char,
  output logic        err,
  output logic [2:0]  rot_valid,
  output logic [2:0]  rot_en,
  output logic        rot_dec,
  output logic [7:0]  rot_din,
  input  logic [23:0] rot_dout,
  input  logic [2:0]  rot_done
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, STEP, FEED, WAIT, OUT} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      k_reg, k_next;
  logic [4:0]      cnt0_reg, cnt0_next;
  logic [4:0]      cnt1_reg, cnt1_next;
  logic [7:0]      work_reg, work_next;
  logic            dec_reg, dec_next;
  logic [TW-1:0]   tcnt_reg, tcnt_next;
  logic            run_reg;
  logic            done_k;
  logic [7:0]      dout_k;

  // run_reg keeps in_ready low until the first edge after reset releases
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      k_reg     <= 2'd0;
      cnt0_reg  <= 5'd0;
      cnt1_reg  <= 5'd0;
      work_reg  <= 8'd0;
      dec_reg   <= 1'b0;
      tcnt_reg  <= '0;
      run_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      cnt0_reg  <= cnt0_next;
      cnt1_reg  <= cnt1_next;
      work_reg  <= work_next;
      dec_reg   <= dec_next;
      tcnt_reg  <= tcnt_next;
      run_reg   <= 1'b1;
    end
  end

  always_comb begin
    done_k = 1'b0;
    dout_k = 8'd0;
    case (k_reg)
      2'd0: begin done_k = rot_done[0]; dout_k = rot_dout[7:0];   end
      2'd1: begin done_k = rot_done[1]; dout_k = rot_dout[15:8];  end
      2'd2: begin done_k = rot_done[2]; dout_k = rot_dout[23:16]; end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    cnt0_next  = cnt0_reg;
    cnt1_next  = cnt1_reg;
    work_next  = work_reg;
    dec_next   = dec_reg;
    tcnt_next  = tcnt_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    err        = 1'b0;
    rot_valid  = 3'b000;
    rot_en     = 3'b000;
    rot_din    = 8'd0;
    case (state_reg)
      IDLE: begin
        in_ready = run_reg;
        if (run_reg && in_valid) begin
          work_next  = in_char;
          dec_next   = dec;
          state_next = STEP;
`ifdef ALPHA_CHECK_EN
          if (in_char < 8'd65 || in_char > 8'd90) state_next = OUT;
`endif
        end
      end
      STEP: begin
        rot_en[0] = 1'b1;
        rot_en[1] = (cnt0_reg == 5'd25);
        rot_en[2] = (cnt0_reg == 5'd25) && (cnt1_reg == 5'd25);
        if (cnt0_reg == 5'd25) begin
          cnt0_next = 5'd0;
          cnt1_next = (cnt1_reg == 5'd25) ? 5'd0 : cnt1_reg + 5'd1;
        end else begin
          cnt0_next = cnt0_reg + 5'd1;
        end
        k_next     = dec_reg ? 2'd2 : 2'd0;
        state_next = FEED;
      end
      FEED: begin
        rot_valid  = 3'b001 << k_reg;
        rot_din    = work_reg;
        tcnt_next  = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (done_k) begin
          work_next = dout_k;
          if (k_reg == (dec_reg ? 2'd0 : 2'd2)) begin
            state_next = OUT;
          end else begin
            k_next     = dec_reg ? k_reg - 2'd1 : k_reg + 2'd1;
            state_next = FEED;
          end
        end else if (tcnt_reg == TW'(TIMEOUT - 1)) begin
          err        = 1'b1;
          state_next = IDLE;
        end else begin
          tcnt_next = tcnt_reg + TW'(1);
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_char = work_reg;
  assign rot_dec  = dec_reg;

endmodule

// File: tb/tb_enigma_ctrl.sv
// Bench for enigma_ctrl: behavioural rotor responders plus a reference model of the
// stepping sequence (step count modulo 26 / 676) and the rotor composition order.
module tb_enigma_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, dec = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, err, rot_dec;
  logic [7:0] in_char = 8'd0, out_char, rot_din;
  logic [2:0] rot_valid, rot_en, rot_done = 3'b000, stall = 3'b000;
  logic [23:0] rot_dout = 24'd0;

  int n_cmp = 0, n_bad = 0, step_count = 0, delay_cfg = 2;
  int ctr[3];
  logic [7:0] din_l[3];

  logic [7:0] obs_out, obs_din[3];
  logic [2:0] obs_en;
  int obs_lat, obs_en_extra, obs_nv, obs_sig, obs_din_idle, obs_ready_bad;
  int obs_err_cyc, obs_v1_cyc, obs_stable_bad;
  logic obs_err, obs_outv, obs_dec, obs_post_ready, obs_post_valid, obs_post_err;

  always #5 clk = ~clk;

  enigma_ctrl #(.TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .dec(dec), .out_valid(out_valid), .out_ready(out_ready),
    .out_char(out_char), .err(err), .rot_valid(rot_valid), .rot_en(rot_en),
    .rot_dec(rot_dec), .rot_din(rot_din), .rot_dout(rot_dout), .rot_done(rot_done)
  );

  // Rotor k substitution used by the responders and the reference model.
  function automatic logic [7:0] rot_f(int k, logic [7:0] x);
    return 8'(int'(x) * (2 * k + 3) + 17 * k + 5);
  endfunction

  function automatic logic [7:0] ref_char(logic [7:0] ch, logic d);
    if (d) return rot_f(0, rot_f(1, rot_f(2, ch)));
    return rot_f(2, rot_f(1, rot_f(0, ch)));
  endfunction

  // Step s (0-based since reset): fast rotor every time, middle every 26th, slow every 676th.
  function automatic logic [2:0] exp_en(int s);
    return {(s % 676) == 675, (s % 26) == 25, 1'b1};
  endfunction

  function automatic bit bypass(logic [7:0] ch);
`ifdef ALPHA_CHECK_EN
    return (ch < 8'd65) || (ch > 8'd90);
`else
    return 1'b0;
`endif
  endfunction

  // Each rotor answers delay_cfg cycles after its start pulse unless stalled.
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) ctr[k] = 0;
      rot_done = 3'b000;
    end else begin
      for (int k = 0; k < 3; k++) begin
        rot_done[k] = 1'b0;
        if (ctr[k] > 0) begin
          ctr[k] = ctr[k] - 1;
          if (ctr[k] == 0 && !stall[k]) begin
            rot_done[k] = 1'b1;
            rot_dout[8*k +: 8] = rot_f(k, din_l[k]);
          end
        end
        if (!rot_done[k]) rot_dout[8*k +: 8] = 8'($urandom);
        if (rot_valid[k]) begin ctr[k] = delay_cfg; din_l[k] = rot_din; end
      end
    end
  end

  task automatic run_char(input logic [7:0] ch, input logic d, input int bp);
    int cyc, w;
    bit fin;
    obs_out = 0; obs_lat = -1; obs_en = 0; obs_en_extra = 0; obs_nv = 0; obs_sig = 0;
    obs_din_idle = 0; obs_ready_bad = 0; obs_err = 0; obs_err_cyc = -1; obs_v1_cyc = -1;
    obs_stable_bad = 0; obs_outv = 0; obs_dec = 0; obs_post_ready = 0; obs_post_valid = 1; obs_post_err = 1;
    for (int i = 0; i < 3; i++) obs_din[i] = 0;
    @(negedge clk);
    in_valid = 1; in_char = ch; dec = d; out_ready = (bp == 0);
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; in_char = 8'($urandom); dec = ~d;
    cyc = 1; fin = 0;
    while (!fin && cyc <= 2000) begin
      if (cyc == 1) begin obs_en = rot_en; obs_dec = rot_dec; end
      else if (rot_en != 0) obs_en_extra++;
      if (rot_valid == 0) begin
        if (rot_din != 0) obs_din_idle++;
      end else begin
        if (obs_nv < 3) obs_din[obs_nv] = rot_din;
        obs_sig = obs_sig * 4 + (rot_valid == 3'b001 ? 0 : rot_valid == 3'b010 ? 1 : rot_valid == 3'b100 ? 2 : 3);
        if (rot_valid == 3'b010 && obs_v1_cyc < 0) obs_v1_cyc = cyc;
        obs_nv++;
      end
      if (in_ready) obs_ready_bad++;
      if (err) begin obs_err = 1; obs_err_cyc = cyc; fin = 1; end
      if (out_valid) begin obs_outv = 1; obs_out = out_char; obs_lat = cyc - 1; fin = 1; end
      if (!fin) begin @(negedge clk); cyc++; end
    end
    if (obs_outv) begin
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        if (!out_valid || out_char !== obs_out || in_ready) obs_stable_bad++;
      end
      out_ready = 1;
      @(posedge clk);
      @(negedge clk);
    end else if (fin) begin
      @(negedge clk);
    end
    obs_post_ready = in_ready; obs_post_valid = out_valid; obs_post_err = err;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if ({in_ready, out_valid, err, rot_valid, rot_en, rot_din, rot_dec, out_char} !== 26'd0) begin
      n_bad++; $display("FAIL reset_outputs got %h want 0", {in_ready, out_valid, err, rot_valid, rot_en, rot_din, rot_dec, out_char}); end
    reset_n = 1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_early got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_first_ready got %b want 1", in_ready); end
    step_count = 0;
  endtask

  task automatic test_encode_a();
    logic [2:0] e;
    delay_cfg = 2;
    run_char(8'h41, 1'b0, 0);
    e = exp_en(step_count); step_count++;
    n_cmp++; if (obs_lat !== 10) begin n_bad++; $display("FAIL encode_a_latency got %0d want 10", obs_lat); end
    n_cmp++; if (obs_en !== e || e !== 3'b001) begin n_bad++; $display("FAIL encode_a_rot_en got %b want %b", obs_en, e); end
    n_cmp++; if (obs_nv !== 3 || obs_sig !== 6) begin n_bad++; $display("FAIL encode_a_order got n=%0d sig=%0d want n=3 sig=6", obs_nv, obs_sig); end
    n_cmp++; if ({obs_din[0], obs_din[1], obs_din[2]} !== {8'h41, rot_f(0, 8'h41), rot_f(1, rot_f(0, 8'h41))}) begin
      n_bad++; $display("FAIL encode_a_rot_din got %h %h %h", obs_din[0], obs_din[1], obs_din[2]); end
    n_cmp++; if (obs_out !== ref_char(8'h41, 1'b0)) begin n_bad++; $display("FAIL encode_a_out got %h want %h", obs_out, ref_char(8'h41, 1'b0)); end
    n_cmp++; if (obs_dec !== 1'b0 || obs_post_ready !== 1'b1 || obs_post_valid !== 1'b0) begin
      n_bad++; $display("FAIL encode_a_dec_post got dec=%b rdy=%b vld=%b want 0 1 0", obs_dec, obs_post_ready, obs_post_valid); end
  endtask

  task automatic test_decode_q();
    logic [2:0] e;
    delay_cfg = 3;
    run_char(8'h51, 1'b1, 0);
    e = exp_en(step_count); step_count++;
    n_cmp++; if (obs_lat !== 13) begin n_bad++; $display("FAIL decode_q_latency got %0d want 13", obs_lat); end
    n_cmp++; if (obs_nv !== 3 || obs_sig !== 36) begin n_bad++; $display("FAIL decode_q_order got n=%0d sig=%0d want n=3 sig=36", obs_nv, obs_sig); end
    n_cmp++; if ({obs_din[0], obs_din[1], obs_din[2]} !== {8'h51, rot_f(2, 8'h51), rot_f(1, rot_f(2, 8'h51))}) begin
      n_bad++; $display("FAIL decode_q_rot_din got %h %h %h", obs_din[0], obs_din[1], obs_din[2]); end
    n_cmp++; if (obs_dec !== 1'b1) begin n_bad++; $display("FAIL decode_q_rot_dec got %b want 1", obs_dec); end
    n_cmp++; if (obs_out !== ref_char(8'h51, 1'b1)) begin n_bad++; $display("FAIL decode_q_out got %h want %h", obs_out, ref_char(8'h51, 1'b1)); end
    n_cmp++; if (obs_en !== e) begin n_bad++; $display("FAIL decode_q_rot_en got %b want %b", obs_en, e); end
  endtask

  task automatic test_backpressure();
    delay_cfg = 1;
    run_char(8'h43, 1'b0, 5);
    step_count++;
    n_cmp++; if (obs_stable_bad !== 0) begin n_bad++; $display("FAIL backpressure_stable got %0d bad cycles want 0", obs_stable_bad); end
    n_cmp++; if (obs_out !== ref_char(8'h43, 1'b0)) begin n_bad++; $display("FAIL backpressure_out got %h want %h", obs_out, ref_char(8'h43, 1'b0)); end
    n_cmp++; if (obs_post_ready !== 1'b1 || obs_post_valid !== 1'b0) begin
      n_bad++; $display("FAIL backpressure_post got rdy=%b vld=%b want 1 0", obs_post_ready, obs_post_valid); end
  endtask

  task automatic test_timeout();
    delay_cfg = 2; stall = 3'b010;
    run_char(8'h42, 1'b0, 0);
    stall = 3'b000; step_count++;
    n_cmp++; if (obs_err !== 1'b1 || obs_outv !== 1'b0) begin n_bad++; $display("FAIL timeout_err got err=%b outv=%b want 1 0", obs_err, obs_outv); end
    n_cmp++; if (obs_err_cyc - obs_v1_cyc !== 255) begin n_bad++; $display("FAIL timeout_wait_cycles got %0d want 255", obs_err_cyc - obs_v1_cyc); end
    n_cmp++; if ({obs_post_ready, obs_post_valid, obs_post_err} !== 3'b100) begin
      n_bad++; $display("FAIL timeout_post got rdy/vld/err=%b want 100", {obs_post_ready, obs_post_valid, obs_post_err}); end
  endtask

`ifdef ALPHA_CHECK_EN
  task automatic test_alpha();
    logic [2:0] e;
    run_char(8'h20, 1'b0, 0);
    n_cmp++; if (obs_out !== 8'h20 || obs_en !== 3'b000 || obs_en_extra !== 0 || obs_nv !== 0) begin
      n_bad++; $display("FAIL alpha_bypass got out=%h en=%b nv=%0d want 20 000 0", obs_out, obs_en, obs_nv); end
    run_char(8'h41, 1'b0, 0);
    e = exp_en(step_count); step_count++;
    n_cmp++; if (obs_en !== e) begin n_bad++; $display("FAIL alpha_counters got %b want %b", obs_en, e); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] ch;
    logic d;
    int bp;
    logic [2:0] e;
    for (int t = 0; t < 30; t++) begin
      ch = 8'($urandom); d = 1'($urandom); bp = $urandom_range(0, 3);
      delay_cfg = $urandom_range(1, 4);
      run_char(ch, d, bp);
      if (bypass(ch)) begin
        n_cmp++; if (obs_out !== ch || obs_en !== 3'b000 || obs_nv !== 0) begin
          n_bad++; $display("FAIL random_bypass ch=%h got out=%h en=%b nv=%0d", ch, obs_out, obs_en, obs_nv); end
      end else begin
        e = exp_en(step_count); step_count++;
        n_cmp++; if (obs_out !== ref_char(ch, d)) begin n_bad++; $display("FAIL random_out ch=%h dec=%b got %h want %h", ch, d, obs_out, ref_char(ch, d)); end
        n_cmp++; if (obs_en !== e) begin n_bad++; $display("FAIL random_rot_en got %b want %b", obs_en, e); end
        n_cmp++; if (obs_lat !== 1 + 3 * (1 + delay_cfg) || obs_sig !== (d ? 36 : 6)) begin
          n_bad++; $display("FAIL random_lat_order got lat=%0d sig=%0d want %0d %0d", obs_lat, obs_sig, 1 + 3 * (1 + delay_cfg), d ? 36 : 6); end
      end
      n_cmp++; if ({obs_stable_bad, obs_din_idle, obs_en_extra, obs_ready_bad} !== 128'd0 || obs_post_ready !== 1'b1 || obs_post_valid !== 1'b0) begin
        n_bad++; $display("FAIL random_protocol got stab=%0d din=%0d en=%0d rdy=%0d post=%b%b", obs_stable_bad, obs_din_idle, obs_en_extra, obs_ready_bad, obs_post_ready, obs_post_valid); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ch;
    logic d;
    logic [2:0] e;
    int n111 = 0;
    delay_cfg = 1;
    while (step_count < 677) begin
      ch = 8'd65 + 8'($urandom_range(0, 25)); d = 1'($urandom);
      run_char(ch, d, 0);
      e = exp_en(step_count); step_count++;
      if (obs_en === 3'b111) n111++;
      n_cmp++; if (obs_en !== e) begin n_bad++; $display("FAIL wrap_rot_en step=%0d got %b want %b", step_count - 1, obs_en, e); end
      n_cmp++; if (obs_out !== ref_char(ch, d)) begin n_bad++; $display("FAIL wrap_out ch=%h got %h want %h", ch, obs_out, ref_char(ch, d)); end
    end
    n_cmp++; if (n111 !== 1) begin n_bad++; $display("FAIL wrap_all_three got %0d want 1", n111); end
  endtask

  task automatic test_reset_mid();
    int w;
    logic [2:0] e;
    delay_cfg = 4;
    @(negedge clk);
    in_valid = 1; in_char = 8'h44; dec = 1;
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); @(negedge clk);
    in_valid = 0;
    w = 0;
    while (rot_valid == 0 && w < 20) begin @(negedge clk); w++; end
    @(negedge clk);
    reset_n = 0; #1;
    n_cmp++; if ({in_ready, out_valid, err, rot_valid, rot_en, rot_din, rot_dec, out_char} !== 26'd0) begin
      n_bad++; $display("FAIL reset_mid_outputs got %h want 0", {in_ready, out_valid, err, rot_valid, rot_en, rot_din, rot_dec, out_char}); end
    repeat (2) @(negedge clk);
    reset_n = 1; step_count = 0;
    for (int t = 0; t < 27; t++) begin
      run_char(8'h41 + 8'(t % 26), 1'b0, 0);
      e = exp_en(step_count); step_count++;
      n_cmp++; if (obs_en !== e) begin n_bad++; $display("FAIL reset_mid_cnt step=%0d got %b want %b", step_count - 1, obs_en, e); end
    end
  endtask

  initial begin
    test_reset();
    test_encode_a();
    test_decode_q();
    test_backpressure();
    test_timeout();
`ifdef ALPHA_CHECK_EN
    test_alpha();
`endif
    test_random();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired after %0d compares", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
